// File: rtl/gate_seq_defs.sv
// Shared definitions for the gate sequence checker: FSM state encoding and
// default run configuration.
package gate_seq_defs;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DRIVE  = 3'd1,
    S_WAIT   = 3'd2,
    S_SAMPLE = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  localparam int DEF_N_VEC  = 8;
  localparam int DEF_SETTLE = 1;
  localparam int DEF_CNT_W  = 4;

  function automatic logic is_busy(input state_t s);
    return (s == S_DRIVE) || (s == S_WAIT) || (s == S_SAMPLE);
  endfunction

endpackage

// File: rtl/gate_seq_checker_if.sv
// Run-control and DUT-drive signals of the gate sequence checker.
// master = checker side, slave = lab top / gate-cell side.
interface gate_seq_checker_if
  import gate_seq_defs::*;
#(
  parameter int CNT_W = DEF_CNT_W
);
  logic             start;
  logic             dut_out;
  logic             dut_in;
  logic             busy;
  logic             done;
  logic             pass;
  logic [CNT_W-1:0] err_cnt;
  logic [7:0]       vec_idx;

  modport master (
    input  start, dut_out,
    output dut_in, busy, done, pass, err_cnt, vec_idx
  );

  modport slave (
    output start, dut_out,
    input  dut_in, busy, done, pass, err_cnt, vec_idx
  );
endinterface

// File: rtl/settle_timer.sv
// 4-bit settle down-counter; expire is high while the count sits at 1, so a
// load of N yields N cycles before expiry.
module settle_timer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [3:0] value,
  output logic       expire
);
  logic [3:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= 4'd0;
    end else if (load) begin
      r_cnt <= value;
    end else if (r_cnt != 4'd0) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  assign expire = (r_cnt == 4'd1);
endmodule

// File: rtl/gate_seq_checker.sv
// Alternating-pattern stimulus sequencer and mismatch counter for an inverting
// gate. Define GATE_SEQ_XCHK_EN to make X/Z on dut_out count as a mismatch.
module gate_seq_checker
  import gate_seq_defs::*;
#(
  parameter int N_VEC  = DEF_N_VEC,
  parameter int SETTLE = DEF_SETTLE,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic                clk,
  input  logic                rst_n,
  gate_seq_checker_if.master  bus
);
  localparam logic [7:0] LAST_IDX   = 8'(N_VEC - 1);
  localparam logic [3:0] SETTLE_VAL = 4'(SETTLE);

  state_t           r_state;
  state_t           w_state_next;
  logic             r_dut_in;
  logic             r_busy;
  logic             r_done;
  logic [CNT_W-1:0] r_err_cnt;
  logic [7:0]       r_vec_idx;
  logic             w_load;
  logic             w_expire;
  logic             w_mismatch;

  settle_timer u_settle_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (w_load),
    .value  (SETTLE_VAL),
    .expire (w_expire)
  );

`ifdef GATE_SEQ_XCHK_EN
  assign w_mismatch = (bus.dut_out !== ~r_dut_in);
`else
  // Logical compare: an unknown result is not taken as a mismatch.
  assign w_mismatch = (bus.dut_out != ~r_dut_in);
`endif

  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (bus.start) w_state_next = S_DRIVE;
      end
      S_DRIVE: begin
        if (SETTLE == 0) begin
          w_state_next = S_SAMPLE;
        end else begin
          w_state_next = S_WAIT;
          w_load       = 1'b1;
        end
      end
      S_WAIT: begin
        if (w_expire) w_state_next = S_SAMPLE;
      end
      S_SAMPLE: begin
        w_state_next = (r_vec_idx == LAST_IDX) ? S_DONE : S_DRIVE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_dut_in  <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err_cnt <= '0;
      r_vec_idx <= 8'd0;
    end else begin
      r_state <= w_state_next;
      r_busy  <= is_busy(w_state_next);
      r_done  <= (w_state_next == S_DONE);
      case (r_state)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            r_dut_in  <= 1'b0;
            r_err_cnt <= '0;
            r_vec_idx <= 8'd0;
          end
        end
        S_DRIVE: r_dut_in <= ~r_dut_in;
        S_SAMPLE: begin
          if (w_mismatch && (r_err_cnt != {CNT_W{1'b1}})) begin
            r_err_cnt <= r_err_cnt + CNT_W'(1);
          end
          if (r_vec_idx != LAST_IDX) r_vec_idx <= r_vec_idx + 8'd1;
        end
        default: ;
      endcase
    end
  end

  assign bus.dut_in  = r_dut_in;
  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.pass    = r_done && (r_err_cnt == '0);
  assign bus.err_cnt = r_err_cnt;
  assign bus.vec_idx = r_vec_idx;
endmodule
